v810_ifq: RTL and testbench
===========================

# v810_ifq

Instruction prefetch queue between the `v810_exec` instruction-fetch port (`IA`/`ID`/`IREQ`/`IACK`) and the `v810_mem` instruction port (`EUIA`/`EUID`/`EUIREQ`/`EUIACK`). It prefetches aligned 32-bit words ahead of the EU from the MAU, and assembles the 32-bit `ID` the EU wants at any halfword-aligned `IA`. On any non-sequential `IA` (branch, jump, trap) it flushes and restarts fetching at the new address.

## Interface
- `DEPTH`, 4: queue capacity in 32-bit words; power of two, ≥2.
- `CLK` in 1: clock.
- `RESn` in 1: reset, synchronous, active-low.
- `CE` in 1: clock enable. All state advances only on `CLK` edges with `CE`=1.
- `IA` in 32: EU fetch address, halfword aligned. `IA[0]` is ignored.
- `IREQ` in 1: EU fetch request.
- `ID` out 32: instruction bits starting at `IA`.
- `IACK` out 1: `ID` valid, one-cycle pulse.
- `MIA` out 32: MAU fetch address, word aligned; drives `v810_mem.EUIA`.
- `MIREQ` out 1: MAU fetch request; drives `EUIREQ`.
- `MID` in 32: MAU fetch data; from `EUID`.
- `MIACK` in 1: MAU fetch acknowledge; from `EUIACK`.

## Operation
- **State:**
  - circular word buffer, `rd_ptr`/`wr_ptr` (log2 DEPTH bits, wrapping).
  - `count` (0..DEPTH).
  - `head_a[31:2]`: word address of the head entry.
  - `fetch_a[31:2]`: next word to request.
  - `pend`: one MAU request outstanding.
  - `discard`: the outstanding response is stale.
- **EU lookup:** when `IREQ`=1 and no `IACK` this cycle, let `w`=`IA[31:2]`.
  - `w`==`head_a`, `IA[1]`=0, `count`≥1 → hit; `ID`=word(`head_a`).
  - `w`==`head_a`, `IA[1]`=1, `count`≥2 → hit; `ID`={word(`head_a`+1)[15:0], word(`head_a`)[31:16]}.
  - `w`==`head_a`+1 and `count`≥1 → pop head (`head_a`++), then look up again next cycle.
  - Any other `w`, or `count`==0 with `w`≠`head_a` → flush:
    - `count`←0, `head_a`←`w`, `fetch_a`←`w`.
    - If `pend`, set `discard`.
  - Otherwise (correct address, data not yet arrived) → wait.
- **Prefetch:** when `MIREQ`=0 and `count`+`pend` < DEPTH, raise `MIREQ` with `MIA`={`fetch_a`,2'b00} and set `pend`.
- **Response:** on `MIACK`=1:
  - Clear `pend`.
  - If `discard`: clear `discard` and drop `MID`; `fetch_a` is unchanged.
  - Else: write `MID` at `wr_ptr`, `count`++, `fetch_a`++.
- **Flush with a request outstanding:** the request is never aborted. `MIREQ`/`MIA` stay until `MIACK`, and the new-address fetch is issued afterward.
- **Simultaneous events:**
  - Pop and MAU write in the same cycle → `count` unchanged, both pointers advance.
  - Flush and a non-discarded `MIACK` in the same cycle → flush wins, the data is dropped.
- **Address arithmetic:** word addresses are 30-bit and wrap, so 0xFFFFFFFC+4 = 0x00000000. Spanning fetches at `IA`=0xFFFFFFFE use word 0.
- **Out of reset:** the first `IREQ` always misses and flushes to `IA`.

## Timing
- **Reset values:**
  - `IACK`=0, `ID`=0, `MIREQ`=0, `MIA`=0.
  - `count`=0, `pend`=0, `discard`=0, pointers 0, `head_a`=0, `fetch_a`=0.
- **Reset mid-operation:** abandons any outstanding MAU transfer; `v810_mem` is reset with the same `RESn`.
- **EU handshake:**
  - EU holds `IREQ`=1 and `IA` stable until it samples `IACK`=1.
  - `IACK`/`ID` are registered; a hit detected in cycle N gives `IACK` in cycle N+1.
  - The EU may present a new `IA` in cycle N+2. The lookup is inhibited during the `IACK` cycle.
- **MAU handshake:**
  - `MIREQ` and `MIA` are held stable until `MIACK`=1 is sampled.
  - `MID` is valid with `MIACK`.
  - A new request may be raised in the cycle after `MIACK`, giving at most one request per two cycles.
- **Latency:**
  - Sequential hit: 1 cycle.
  - Miss with zero-wait MAU (`MIACK` 1 cycle after `MIREQ`): the `IA[1]`=0 case returns `IACK` 3 cycles after `IREQ`. The spanning case adds 2 cycles.
- **CE=0:** freezes all state and outputs.

## Structure
- Add `IFQ_DEPTH_DEFAULT` to shared package `v810_pkg`.
- Add `ifq_addr_t`, `logic [31:2]`, to the same package.
- Sub-module `v810_ifq_buf`: DEPTH×32 circular register file.
  - One write port.
  - Two read ports: head and head+1.
  - Pointer and count logic stays in `v810_ifq`.

## Test plan
- **Sequential stream:** reset, then `IA`=0x80000000,+2,+4,… with zero-wait MAU. The first `IACK` arrives 3 cycles after `IREQ`; every later one is 1 cycle after `IREQ`. `MIA` increments by 4, and `count` never exceeds DEPTH.
- **Spanning fetch:** word0=0x22221111, word1=0x44443333, `IA`=0x80000002 → `ID`=0x33332222.
- **Branch flush:** queue full at 0x80000000, then `IA`=0x80000100. Next `MIA`=0x80000100, and `ID` comes from the new word.
- **Flush with outstanding fetch:** 3-wait MAU, flush mid-request. The old `MIA` is held until `MIACK`, its data is discarded, and the new address is requested on the following cycle.
- **Wrap:** `IA`=0xFFFFFFFE with word(0xFFFFFFFC)=0xAAAA0000 and word(0)=0x0000BBBB → `ID`=0xBBBBAAAA, and `MIA` sequence 0xFFFFFFFC, 0x00000000.
- **Reset mid-request:** drop `RESn` while `MIREQ`=1. The next cycle shows `MIREQ`=0 and `IACK`=0, and the first post-reset `IREQ` misses.

Source files
------------

// File: rtl/v810_pkg.sv
// v810 shared definitions.
// Used by the fetch path and its queue.
package v810_pkg;

   localparam int IFQ_DEPTH_DEFAULT = 4;

   typedef logic [31:2] ifq_addr_t;

endpackage

// File: rtl/v810_ifq_buf.sv
// v810 prefetch queue storage.
// Circular word file, one write port, head and head+1 reads.
module v810_ifq_buf
   import v810_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT
)
(
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
   input  logic [31:0]                wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
   output logic [31:0]                rd0,
   output logic [31:0]                rd1
);

   localparam int PW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] rd_nx;

   assign rd_nx = rd_ptr + PW'(1);
   assign rd0   = mem[rd_ptr];
   assign rd1   = mem[rd_nx];

   // Capture returned fetch words at the tail.
   always_ff @(posedge clk) begin
      if (we)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/v810_ifq.sv
// v810 instruction prefetch queue.
// Prefetches words from the MAU and serves halfword-aligned fetches.
module v810_ifq
   import v810_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT
)
(
   input  logic        CLK,
   input  logic        RESn,
   input  logic        CE,
   input  logic [31:0] IA,
   input  logic        IREQ,
   output logic [31:0] ID,
   output logic        IACK,
   output logic [31:0] MIA,
   output logic        MIREQ,
   input  logic [31:0] MID,
   input  logic        MIACK
);

   localparam int            PW   = $clog2(DEPTH);
   localparam int            CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   ifq_addr_t     head_a;
   ifq_addr_t     fetch_a;
   logic          pend;
   logic          discard;
   logic          hvalid;
   logic          iack_q;
   logic [31:0]   id_q;
   logic [31:0]   mia_q;

   logic [31:0]   word0;
   logic [31:0]   word1;

   ifq_addr_t     w;
   ifq_addr_t     head_nx;
   logic          look;
   logic          at_head;
   logic          at_next;
   logic          hit0;
   logic          hit1;
   logic          hitp;
   logic          hit;
   logic          pop;
   logic          flush;
   logic          ack_ok;
   logic          wr_en;
   logic [CW-1:0] count_n;
   ifq_addr_t     fetch_n;
   logic          hvalid_n;
   logic          issue;
   logic [31:0]   hit_data;

   logic          unused_ia0;

   assign unused_ia0 = IA[0];

   v810_ifq_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (CLK),
      .we      (CE && wr_en),
      .wr_ptr  (wr_ptr),
      .wr_data (MID),
      .rd_ptr  (rd_ptr),
      .rd0     (word0),
      .rd1     (word1)
   );

   // Lookup decode, response accept and prefetch decision.
   always_comb begin
      w        = IA[31:2];
      head_nx  = head_a + 30'd1;
      look     = IREQ && !iack_q;
      at_head  = hvalid && (w == head_a);
      at_next  = hvalid && (w == head_nx);
      hit0     = look && at_head && !IA[1]
               && (count != '0);
      hit1     = look && at_head && IA[1]
               && (count >= CW'(2));
      pop      = look && at_next && (count != '0);
      // Popping into a full next word serves it at once.
      hitp     = pop && !IA[1] && (count >= CW'(2));
      hit      = hit0 || hit1 || hitp;
      flush    = look && !at_head && !pop;
      ack_ok   = pend && MIACK;
      wr_en    = ack_ok && !discard && !flush;
      hvalid_n = hvalid || flush;

      count_n  = count + CW'(wr_en) - CW'(pop);
      fetch_n  = wr_en ? fetch_a + 30'd1 : fetch_a;
      if (flush) begin
         count_n = '0;
         fetch_n = w;
      end

      issue    = hvalid_n && !pend && (count_n < FULL);

      unique case (1'b1)
         hit1:    hit_data = {word1[15:0], word0[31:16]};
         hitp:    hit_data = word1;
         default: hit_data = word0;
      endcase
   end

   // Queue, fetch and handshake state.
   always_ff @(posedge CLK) begin
      if (!RESn) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         head_a  <= '0;
         fetch_a <= '0;
         pend    <= 1'b0;
         discard <= 1'b0;
         hvalid  <= 1'b0;
         iack_q  <= 1'b0;
         id_q    <= '0;
         mia_q   <= '0;
      end else if (CE) begin
         iack_q  <= hit;
         if (hit)
            id_q <= hit_data;
         count   <= count_n;
         fetch_a <= fetch_n;
         hvalid  <= hvalid_n;
         if (flush) begin
            head_a <= w;
            rd_ptr <= wr_ptr;
         end else if (pop) begin
            head_a <= head_nx;
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (wr_en)
            wr_ptr <= wr_ptr + PW'(1);
         if (ack_ok)
            pend <= 1'b0;
         else if (issue)
            pend <= 1'b1;
         if (issue)
            mia_q <= {fetch_n, 2'b00};
         if (flush)
            discard <= pend && !MIACK;
         else if (ack_ok)
            discard <= 1'b0;
      end
   end

   assign ID    = id_q;
   assign IACK  = iack_q;
   assign MIA   = mia_q;
   assign MIREQ = pend;

endmodule

// File: tb/tb_v810_ifq.sv
// Bench for the v810 prefetch queue.
// Scenario tasks against a memory-image reference.
module tb_v810_ifq;
   import v810_pkg::*;

   localparam int DEPTH = IFQ_DEPTH_DEFAULT;

   logic        CLK   = 1'b0;
   logic        RESn  = 1'b0;
   logic        CE    = 1'b1;
   logic [31:0] IA    = '0;
   logic        IREQ  = 1'b0;
   logic [31:0] MID   = '0;
   logic        MIACK = 1'b0;
   logic [31:0] ID;
   logic        IACK;
   logic [31:0] MIA;
   logic        MIREQ;

   int checks = 0;
   int errors = 0;
   int mau_min = 0;
   int mau_max = 0;
   int max_cnt = 0;

   logic [31:0] mia_log[$];
   logic [31:0] mem [logic [29:0]];

   v810_ifq #(.DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .RESn  (RESn),
      .CE    (CE),
      .IA    (IA),
      .IREQ  (IREQ),
      .ID    (ID),
      .IACK  (IACK),
      .MIA   (MIA),
      .MIREQ (MIREQ),
      .MID   (MID),
      .MIACK (MIACK)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_rd(input logic [29:0] wa);
      if (mem.exists(wa))
         return mem[wa];
      return {wa[15:0], wa[29:14]} ^ 32'h5a3c_96e1;
   endfunction

   function automatic logic [31:0] model_id(input logic [31:0] a);
      logic [29:0] wa;
      logic [31:0] lo;
      logic [31:0] hi;
      wa = a[31:2];
      lo = mem_rd(wa);
      hi = mem_rd(wa + 30'd1);
      return a[1] ? {hi[15:0], lo[31:16]} : lo;
   endfunction

   always @(negedge CLK)
      if (int'(dut.count) > max_cnt)
         max_cnt = int'(dut.count);

   // MAU model: random wait states, holds while CE is low.
   initial begin : mau
      int   wcnt;
      int   tgt;
      logic busy;
      logic [31:0] prev_mia;
      wcnt = 0; tgt = 0; busy = 1'b0; prev_mia = '0;
      forever begin
         @(negedge CLK);
         if (!RESn) begin
            MIACK = 1'b0; wcnt = 0; busy = 1'b0;
         end else if (CE) begin
            if (MIREQ) begin
               if (!busy) begin
                  mia_log.push_back(MIA);
                  tgt = $urandom_range(mau_max, mau_min);
                  prev_mia = MIA;
                  checks++;
                  if (MIA[1:0] !== 2'b00) begin
                     errors++;
                     $display("FAIL mia_align: got %h", MIA);
                  end
               end else begin
                  checks++;
                  if (MIA !== prev_mia) begin
                     errors++;
                     $display("FAIL mia_hold: got %h expected %h",
                              MIA, prev_mia);
                  end
               end
               if (wcnt == tgt) begin
                  MIACK = 1'b1; MID = mem_rd(MIA[31:2]);
                  wcnt = 0; busy = 1'b0;
               end else begin
                  MIACK = 1'b0; wcnt++; busy = 1'b1;
               end
            end else begin
               MIACK = 1'b0; wcnt = 0; busy = 1'b0;
            end
         end
      end
   end

   task automatic do_reset();
      IREQ = 1'b0; CE = 1'b1; RESn = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RESn = 1'b1;
      mia_log.delete();
   endtask

   // Present IA, wait for IACK; lat=-1 on timeout.
   task automatic eu_fetch(input logic [31:0] a,
                           output logic [31:0] d,
                           output int lat);
      IA = a; IREQ = 1'b1; lat = -1; d = 'x;
      for (int i = 1; i <= 80; i++) begin
         @(posedge CLK); #1;
         if (IACK === 1'b1) begin
            lat = i; d = ID;
            break;
         end
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (IACK !== 1'b0) begin
         errors++; $display("FAIL rst_iack: got %b expected 0", IACK);
      end
      checks++;
      if (ID !== 32'h0) begin
         errors++; $display("FAIL rst_id: got %h expected 0", ID);
      end
      checks++;
      if (MIREQ !== 1'b0) begin
         errors++; $display("FAIL rst_mireq: got %b expected 0", MIREQ);
      end
      checks++;
      if (MIA !== 32'h0) begin
         errors++; $display("FAIL rst_mia: got %h expected 0", MIA);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] a;
      logic [31:0] d;
      int lat;
      do_reset();
      mau_min = 0; mau_max = 0; max_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         a = 32'h8000_0000 + 32'(2 * i);
         eu_fetch(a, d, lat);
         checks++;
         if (d !== model_id(a)) begin
            errors++;
            $display("FAIL seq_id[%0d]: got %h expected %h",
                     i, d, model_id(a));
         end
         checks++;
         if (lat != ((i == 0) ? 3 : 1)) begin
            errors++;
            $display("FAIL seq_lat[%0d]: got %0d expected %0d",
                     i, lat, (i == 0) ? 3 : 1);
         end
      end
      checks++;
      if (IACK !== 1'b0) begin
         errors++; $display("FAIL iack_pulse: got %b expected 0", IACK);
      end
      IREQ = 1'b0;
      checks++;
      if (mia_log.size() == 0 || mia_log[0] !== 32'h8000_0000) begin
         errors++; $display("FAIL seq_mia0: log size %0d", mia_log.size());
      end
      for (int i = 1; i < mia_log.size(); i++) begin
         checks++;
         if (mia_log[i] !== mia_log[i-1] + 32'd4) begin
            errors++;
            $display("FAIL seq_mia_inc[%0d]: got %h expected %h",
                     i, mia_log[i], mia_log[i-1] + 32'd4);
         end
      end
      checks++;
      if (max_cnt > DEPTH) begin
         errors++;
         $display("FAIL seq_count: got %0d expected <= %0d", max_cnt, DEPTH);
      end
   endtask

   task automatic test_spanning();
      logic [31:0] d;
      int lat;
      mem[30'h2000_0000] = 32'h2222_1111;
      mem[30'h2000_0001] = 32'h4444_3333;
      do_reset();
      mau_min = 0; mau_max = 0;
      eu_fetch(32'h8000_0002, d, lat);
      IREQ = 1'b0;
      checks++;
      if (d !== 32'h3333_2222) begin
         errors++; $display("FAIL span_id: got %h expected 33332222", d);
      end
      checks++;
      if (lat != 5) begin
         errors++; $display("FAIL span_lat: got %0d expected 5", lat);
      end
   endtask

   task automatic test_branch();
      logic [31:0] d;
      int lat;
      do_reset();
      mau_min = 0; mau_max = 0;
      eu_fetch(32'h8000_0000, d, lat);
      IREQ = 1'b0;
      repeat (20) begin @(posedge CLK); #1; end
      checks++;
      if (MIREQ !== 1'b0 || int'(dut.count) != DEPTH) begin
         errors++;
         $display("FAIL br_full: got mireq %b count %0d expected 0 %0d",
                  MIREQ, dut.count, DEPTH);
      end
      mia_log.delete();
      eu_fetch(32'h8000_0100, d, lat);
      IREQ = 1'b0;
      checks++;
      if (mia_log.size() == 0 || mia_log[0] !== 32'h8000_0100) begin
         errors++; $display("FAIL br_mia: expected first 80000100");
      end
      checks++;
      if (d !== model_id(32'h8000_0100)) begin
         errors++;
         $display("FAIL br_id: got %h expected %h",
                  d, model_id(32'h8000_0100));
      end
      checks++;
      if (lat != 3) begin
         errors++; $display("FAIL br_lat: got %0d expected 3", lat);
      end
   endtask

   task automatic test_flush_pending();
      logic [31:0] d;
      logic [31:0] old;
      logic prev;
      logic found;
      int lat;
      int n_hi;
      do_reset();
      mau_min = 3; mau_max = 3;
      eu_fetch(32'h8000_0000, d, lat);
      IREQ = 1'b0;
      prev = MIREQ; found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #1;
         if (MIREQ && !prev) begin
            found = 1'b1;
            break;
         end
         prev = MIREQ;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL fp_rise: got no MIREQ rise expected one");
      end
      old = MIA;
      IA = 32'h8000_0200; IREQ = 1'b1;
      n_hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         if (!MIREQ) break;
         n_hi++;
         checks++;
         if (MIA !== old) begin
            errors++; $display("FAIL fp_hold: got %h expected %h", MIA, old);
         end
      end
      checks++;
      if (n_hi != 3) begin
         errors++; $display("FAIL fp_hold_len: got %0d expected 3", n_hi);
      end
      @(posedge CLK); #1;
      checks++;
      if (MIREQ !== 1'b1 || MIA !== 32'h8000_0200) begin
         errors++;
         $display("FAIL fp_newreq: got %b %h expected 1 80000200",
                  MIREQ, MIA);
      end
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #1;
         if (IACK === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || ID !== model_id(32'h8000_0200)) begin
         errors++;
         $display("FAIL fp_id: got %b %h expected 1 %h",
                  found, ID, model_id(32'h8000_0200));
      end
      @(posedge CLK); #1;
      IREQ = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      int lat;
      mem[30'h3fff_ffff] = 32'haaaa_0000;
      mem[30'h0000_0000] = 32'h0000_bbbb;
      do_reset();
      mau_min = 0; mau_max = 0;
      eu_fetch(32'hffff_fffe, d, lat);
      IREQ = 1'b0;
      checks++;
      if (d !== 32'hbbbb_aaaa) begin
         errors++; $display("FAIL wrap_id: got %h expected bbbbaaaa", d);
      end
      checks++;
      if (lat != 5) begin
         errors++; $display("FAIL wrap_lat: got %0d expected 5", lat);
      end
      checks++;
      if (mia_log.size() < 2 || mia_log[0] !== 32'hffff_fffc
          || mia_log[1] !== 32'h0) begin
         errors++;
         $display("FAIL wrap_mia: size %0d expected fffffffc,00000000",
                  mia_log.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic found;
      int lat;
      do_reset();
      mau_min = 3; mau_max = 3;
      IA = 32'h4000_0000; IREQ = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         if (MIREQ === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL rm_req: got no MIREQ expected one");
      end
      RESn = 1'b0; IREQ = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (MIREQ !== 1'b0 || IACK !== 1'b0) begin
         errors++;
         $display("FAIL rm_idle: got %b %b expected 0 0", MIREQ, IACK);
      end
      RESn = 1'b1;
      mau_min = 0; mau_max = 0;
      mia_log.delete();
      eu_fetch(32'h0, d, lat);
      IREQ = 1'b0;
      checks++;
      if (lat != 3) begin
         errors++; $display("FAIL rm_lat: got %0d expected 3", lat);
      end
      checks++;
      if (d !== model_id(32'h0)) begin
         errors++;
         $display("FAIL rm_id: got %h expected %h", d, model_id(32'h0));
      end
      checks++;
      if (mia_log.size() == 0 || mia_log[0] !== 32'h0) begin
         errors++; $display("FAIL rm_mia: expected first 00000000");
      end
   endtask

   task automatic test_ce();
      logic found;
      int n;
      do_reset();
      mau_min = 3; mau_max = 3;
      IA = 32'h8000_0400; IREQ = 1'b1;
      n = 0;
      repeat (2) begin @(posedge CLK); #1; n++; end
      CE = 1'b0;
      repeat (4) begin
         @(posedge CLK); #1; n++;
         checks++;
         if (MIREQ !== 1'b1 || MIA !== 32'h8000_0400
             || IACK !== 1'b0 || ID !== 32'h0) begin
            errors++;
            $display("FAIL ce_hold: got %b %h %b %h expected 1 80000400 0 0",
                     MIREQ, MIA, IACK, ID);
         end
      end
      CE = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge CLK); #1; n++;
         if (IACK === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || n != 10) begin
         errors++; $display("FAIL ce_lat: got %b %0d expected 1 10", found, n);
      end
      checks++;
      if (ID !== model_id(32'h8000_0400)) begin
         errors++;
         $display("FAIL ce_id: got %h expected %h",
                  ID, model_id(32'h8000_0400));
      end
      @(posedge CLK); #1;
      IREQ = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] d;
      int lat;
      int r;
      do_reset();
      mau_min = 0; mau_max = 3;
      a = 32'h1000_0000;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(99, 0);
         if (r < 60)
            a = a + 32'd2;
         else if (r < 75)
            a = a + 32'd4;
         else if (r < 90)
            a = 32'h1000_0000 + 32'($urandom_range(255, 0) * 2);
         else
            a = $urandom & 32'hffff_fffe;
         eu_fetch(a, d, lat);
         checks++;
         if (lat < 0) begin
            errors++; $display("FAIL rnd_timeout[%0d]: addr %h", n, a);
         end
         checks++;
         if (d !== model_id(a)) begin
            errors++;
            $display("FAIL rnd_id[%0d]: addr %h got %h expected %h",
                     n, a, d, model_id(a));
         end
         if ($urandom_range(3, 0) == 0) begin
            IREQ = 1'b0;
            repeat ($urandom_range(6, 1)) begin @(posedge CLK); #1; end
         end
      end
      IREQ = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge CLK); #1;
      test_reset();
      test_sequential();
      test_spanning();
      test_branch();
      test_flush_pending();
      test_wrap();
      test_reset_mid();
      test_ce();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
